// File: rtl/iiitb_tlc_sensor_cond.sv
// iiitb_tlc_sensor_cond
// Conditions the farm-road vehicle loop detector for the traffic light
// controller. The raw loop is synchronized and debounced into a presence
// level. A small FSM turns presence into a latched vehicle request
// (sensor), and the request is held while the farm road is served.
//
// Ports
//   clk          single clock, rising edge
//   rst_n        asynchronous active-low reset
//   loop_raw     raw loop detector, asynchronous to clk, may bounce
//   light_farm   farm-road light: 3'b100 RED, 3'b010 YELLOW, 3'b001 GREEN
//   cnt_clr      synchronous clear of veh_count
//   sensor       registered vehicle request to the controller
//   veh_count    registered, saturating count of qualified arrivals
//
// Build option
//   TLC_VEH_COUNT_EN  defined: vehicle counter compiled in.
//                     undefined: veh_count tied to 0 and cnt_clr ignored.
//
// FSM states
//   state | meaning
//   IDLE  | no request pending, sensor low
//   REQ   | request latched, waiting for farm-road GREEN
//   SERVE | farm road green, request held for at least HOLD_CYCLES

module iiitb_tlc_sensor_cond #(
    parameter int unsigned DEBOUNCE_CYCLES = 8,
    parameter int unsigned HOLD_CYCLES     = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       loop_raw,
    input  logic [2:0] light_farm,
    input  logic       cnt_clr,
    output logic       sensor,
    output logic [7:0] veh_count
);

    localparam logic [7:0] DEB_LAST = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0] HOLD_MAX = 8'(HOLD_CYCLES);
    localparam logic [2:0] GREEN    = 3'b001;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        SERVE = 2'd2
    } state_t;

    logic [1:0] rst_sync;
    logic       rst_ok;
    logic [1:0] loop_sync;
    logic       loop_s;
    logic [7:0] deb_cnt;
    logic       pres;
    logic       deb_hit;
    logic       pres_rise;
    logic [7:0] hold_cnt;
    logic       green;
    state_t     state;
    state_t     state_next;

    // Reset release is re-timed so the FSM never leaves IDLE on the
    // same edge the asynchronous reset deasserts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_ok = rst_sync[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) loop_sync <= 2'b00;
        else        loop_sync <= {loop_sync[0], loop_raw};
    end
    assign loop_s = loop_sync[1];

    // Counts consecutive disagreements with pres; any agreement restarts.
    assign deb_hit   = (loop_s != pres) && (deb_cnt == DEB_LAST);
    assign pres_rise = deb_hit && !pres;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_cnt <= 8'd0;
            pres    <= 1'b0;
        end else if (loop_s == pres) begin
            deb_cnt <= 8'd0;
        end else if (deb_hit) begin
            deb_cnt <= 8'd0;
            pres    <= ~pres;
        end else begin
            deb_cnt <= deb_cnt + 8'd1;
        end
    end

    // Cleared in every state but SERVE, so it is zero on SERVE entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 hold_cnt <= 8'd0;
        else if (state != SERVE)    hold_cnt <= 8'd0;
        else if (hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + 8'd1;
    end

    assign green = (light_farm == GREEN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            sensor <= 1'b0;
        end else begin
            state  <= state_next;
            sensor <= (state_next != IDLE);
        end
    end

    // IDLE is only ever entered with pres low, so pres high in IDLE
    // always marks a fresh rising edge.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (pres && rst_ok) state_next = REQ;
            REQ:   if (green) state_next = SERVE;
            SERVE: begin
                if (!green)                          state_next = pres ? REQ : IDLE;
                else if (!pres && hold_cnt == HOLD_MAX) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef TLC_VEH_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          veh_count <= 8'd0;
        else if (cnt_clr)                    veh_count <= 8'd0;
        else if (pres_rise && veh_count != 8'hFF) veh_count <= veh_count + 8'd1;
    end
`else
    logic unused_sig;
    assign unused_sig = cnt_clr ^ pres_rise;
    assign veh_count  = 8'd0;
`endif

endmodule

// File: doc/iiitb_tlc_sensor_cond.md
IIITB_TLC_SENSOR_COND -- requirements
Module: iiitb_tlc_sensor_cond

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 8, consecutive synchronized samples required to change debounced presence (range 2..255).
REQ-002 Parameter: HOLD_CYCLES, default 16, minimum cycles in SERVE before sensor may drop (range 1..255).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 loop_raw  input  1  raw farm-road vehicle loop detector, asynchronous to clk, may bounce.
REQ-006 light_farm  input  3  farm-road light from the controller: 3'b100 RED, 3'b010 YELLOW, 3'b001 GREEN.
REQ-007 cnt_clr  input  1  synchronous clear of veh_count.
REQ-008 sensor  output  1  registered vehicle request to the traffic light controller's sensor input.
REQ-009 veh_count  output  8  registered count of qualified vehicle arrivals.

Function
REQ-010 loop_raw SHALL pass through a 2-flop synchronizer (loop_s); no other logic may use loop_raw.
REQ-011 Debounce: a counter SHALL count consecutive cycles where loop_s differs from the debounced level pres; a match resets it to 0; pres SHALL toggle when the counter reaches DEBOUNCE_CYCLES, and the counter SHALL then reset to 0.
REQ-012 A loop_raw pulse or gap shorter than DEBOUNCE_CYCLES cycles SHALL NOT change pres.
REQ-013 Latency: loop_raw held stable from edge N SHALL toggle pres at edge N+DEBOUNCE_CYCLES+2 (±1 for sampling).
REQ-014 FSM states: IDLE, REQ, SERVE; encoding is free.
REQ-015 IDLE: sensor=0; pres rising -> REQ.
REQ-016 REQ: sensor=1; light_farm==GREEN -> SERVE (hold counter loaded with 0); pres falling before GREEN SHALL NOT leave REQ (request latched).
REQ-017 SERVE: sensor=1; hold counter increments, saturating at HOLD_CYCLES; pres==0 and hold counter==HOLD_CYCLES -> IDLE.
REQ-018 SERVE: light_farm!=GREEN while pres==1 -> REQ (vehicles remain, re-request).
REQ-019 SERVE: light_farm!=GREEN and pres==0 -> IDLE regardless of hold counter.
REQ-020 sensor SHALL be a registered FSM-decoded output, changing only on clk edges, glitch-free.
REQ-021 light_farm values other than the three encodings SHALL be treated as not GREEN.
REQ-022 veh_count SHALL increment by 1 on every pres rising edge, saturating at 255 (no wrap).
REQ-023 cnt_clr and a pres rising edge in the same cycle: clear wins, veh_count=0.

Reset
REQ-024 rst_n low SHALL immediately force: sync flops 0, pres 0, debounce and hold counters 0, FSM IDLE, sensor 0, veh_count 0.
REQ-025 Reset asserted mid-REQ/SERVE SHALL drop sensor at once; after release the block SHALL re-qualify loop_raw from scratch (no pending request retained).
REQ-026 Reset deassertion SHALL be synchronized internally (2-flop) before the FSM leaves IDLE.

Configuration
REQ-027 Macro TLC_VEH_COUNT_EN: defined -> veh_count logic per REQ-022/023 compiled in; undefined -> counter removed, veh_count tied to 8'd0, cnt_clr ignored; FSM and sensor behaviour identical in both builds.

Verification
REQ-028 Reset: rst_n=0 for 20 cycles with loop_raw=1 -> sensor=0, veh_count=0 throughout; after release sensor rises DEBOUNCE_CYCLES+2 (+sync) cycles later.
REQ-029 Glitch: loop_raw=1 for 5 cycles then 0 (DEBOUNCE_CYCLES=8) -> sensor stays 0, veh_count stays 0.
REQ-030 Latching: loop_raw=1 for 20 cycles then 0, light_farm RED -> sensor=1 persists indefinitely; light_farm GREEN at cycle 100 -> sensor drops at cycle 100+HOLD_CYCLES (±2).
REQ-031 Re-request: in SERVE with loop_raw=1, light_farm GREEN->YELLOW -> FSM returns to REQ, sensor stays 1 without a gap.
REQ-032 Count (TLC_VEH_COUNT_EN defined): 300 clean pulses of 20 high/20 low cycles -> veh_count=255; cnt_clr coinciding with pres rising -> veh_count=0; macro undefined -> veh_count=0 always.
REQ-033 Reset mid-SERVE: rst_n=0 one cycle -> sensor=0 same cycle, FSM IDLE, request re-qualified only after a fresh debounce.
